// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver with 16x oversampling.
// Received bytes are held in rxbyte with a valid/acknowledge handshake;
// overrun and frame_err are single-clock registered pulses.
module uart_rx_8n1 #(
   parameter int unsigned CLK_DIV = 78   // system clocks per oversample tick, 2..65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rxack,
   output logic [7:0] rxbyte,
   output logic       rxvalid,
   output logic       overrun,
   output logic       frame_err
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   state_t      state;
   logic        rx_meta;
   logic        rx_s;
   logic [15:0] div_cnt;
   logic [3:0]  samp_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic        tick;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // One oversample tick per CLK_DIV clocks, on the last count.
   assign tick = (div_cnt == DIV_LAST);

   // Receiver FSM with tick/sample/bit counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         samp_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rxbyte    <= '0;
         rxvalid   <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         // Status outputs are pulses unless set below.
         overrun   <= 1'b0;
         frame_err <= 1'b0;

         // Consumer acknowledge; a same-cycle load below overrides this.
         if (rxack && rxvalid) begin
            rxvalid <= 1'b0;
         end

         // The tick counter is parked at zero while idle so a start edge
         // always begins a fresh half-bit measurement.
         if (state == IDLE || tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 16'd1;
         end

         case (state)
            IDLE: begin
               samp_cnt <= '0;
               bit_cnt  <= '0;
               if (!rx_s) begin
                  state <= START;
               end
            end

            START: begin
               if (tick) begin
                  if (samp_cnt == 4'd7) begin
                     // Middle of the start bit: a high line was only a glitch.
                     samp_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= rx_s ? IDLE : DATA;
                  end else begin
                     samp_cnt <= samp_cnt + 4'd1;
                  end
               end
            end

            DATA: begin
               if (tick) begin
                  // Wraps 15 -> 0 at each bit boundary.
                  samp_cnt <= samp_cnt + 4'd1;
                  if (samp_cnt == 4'd15) begin
                     shift   <= {rx_s, shift[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state <= STOP;
                     end
                  end
               end
            end

            STOP: begin
               if (tick) begin
                  samp_cnt <= samp_cnt + 4'd1;
                  if (samp_cnt == 4'd15) begin
                     if (rx_s) begin
                        rxbyte  <= shift;
                        rxvalid <= 1'b1;
                        overrun <= rxvalid && !rxack;
                        state   <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= BRK;
                     end
                  end
               end
            end

            BRK: begin
               // A held-low line (break) must return high before the next frame.
               if (rx_s) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: scoreboard bench for uart_rx_8n1. Stimulus pushes the
// expected receiver events; an independent monitor pops them as the DUT
// reports bytes, overruns and framing errors.
module tb_uart_rx_8n1;

   localparam int CLK_DIV = 5;
   localparam int BIT     = 16 * CLK_DIV;

   typedef enum {K_BYTE, K_OVR, K_FERR} kind_e;
   typedef struct {
      kind_e      kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       manual_ack = 1'b0;
   logic       auto_ack = 1'b0;
   logic       auto_ack_q = 1'b0;
   wire        rxack;
   logic [7:0] rxbyte;
   logic       rxvalid;
   logic       overrun;
   logic       frame_err;

   ev_t         exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned last_start_cyc = 0;
   int unsigned load_cyc = 0;
   bit          model_valid = 1'b0;
   int          lat = 0;

   assign rxack = manual_ack | auto_ack_q;

   uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rxack     (rxack),
      .rxbyte    (rxbyte),
      .rxvalid   (rxvalid),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Free-running count of rising clock edges for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: what one frame should produce, from the protocol rules.
   task automatic model_frame(input logic [7:0] d, input bit stop_ok);
      ev_t e;
      e.data = d;
      if (!stop_ok) begin
         e.kind = K_FERR;
      end else if (model_valid && !auto_ack) begin
         e.kind = K_OVR;
      end else begin
         e.kind = K_BYTE;
      end
      exp_q.push_back(e);
      if (stop_ok) model_valid = !auto_ack;
   endtask

   task automatic set_auto(input bit b);
      auto_ack = b;
      if (b) model_valid = 1'b0;
   endtask

   // Drives one 8N1 frame; entry and exit are 1 time unit after a rising edge.
   // rst_bit >= 0 pulses rst in the middle of that data bit.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int rst_bit);
      rx = 1'b0;
      last_start_cyc = cyc;
      repeat (BIT) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         if (i == rst_bit) begin
            repeat (BIT / 2) @(posedge clk);
            #1 rst = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            repeat (BIT - BIT / 2 - 3) @(posedge clk);
         end else begin
            repeat (BIT) @(posedge clk);
         end
         #1;
      end
      rx = stop_ok;
      repeat (BIT) @(posedge clk);
      #1;
      if (!stop_ok) begin
         repeat (2 * BIT) @(posedge clk);
         #1 rx = 1'b1;
         repeat (BIT / 2) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   task automatic ack_pulse();
      manual_ack = 1'b1;
      @(posedge clk);
      #1 manual_ack = 1'b0;
      check("ack_clears_valid", rxvalid, 1'b0);
      model_valid = 1'b0;
   endtask

   task automatic expect_event(input kind_e k, input logic [7:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event_kind", k, 32'hffff);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", k, e.kind);
         if (k != K_FERR) check("event_data", d, e.data);
      end
   endtask

   // Monitor: samples on the falling edge and scores every DUT report.
   initial begin
      bit prev_valid = 1'b0;
      bit prev_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
            auto_ack_q = 1'b0;
         end else begin
            if (frame_err) expect_event(K_FERR, 8'h00);
            if (rxvalid && !prev_valid) begin
               load_cyc = cyc;
               expect_event(K_BYTE, rxbyte);
               check("no_overrun_on_fresh_load", overrun, 1'b0);
            end
            if (overrun) begin
               expect_event(K_OVR, rxbyte);
               check("valid_held_on_overrun", rxvalid, 1'b1);
            end
            if (prev_valid && !rxvalid) check("valid_cleared_only_by_ack", prev_ack, 1'b1);
            prev_valid = rxvalid;
            auto_ack_q = auto_ack && rxvalid && !auto_ack_q;
            prev_ack   = manual_ack | auto_ack_q;
         end
      end
   end

   initial begin
      logic [7:0] d;
      bit         ok;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_rxbyte", rxbyte, 8'h00);
      check("reset_rxvalid", rxvalid, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Idle line produces nothing.
      repeat (25 * BIT) @(posedge clk);
      #1;
      check("idle_no_valid", rxvalid, 1'b0);

      // Single byte with latency measurement, then acknowledge.
      set_auto(1'b0);
      model_frame(8'hA5, 1'b1);
      send_frame(8'hA5, 1'b1, -1);
      lat = int'(load_cyc - last_start_cyc);
      check("load_latency_in_window",
            (lat >= 152 * CLK_DIV + 1) && (lat <= 152 * CLK_DIV + 4), 1'b1);
      check("single_rxbyte", rxbyte, 8'hA5);
      check("single_rxvalid", rxvalid, 1'b1);
      ack_pulse();

      // Back-to-back frames with immediate acknowledge.
      set_auto(1'b1);
      for (int i = 0; i < 10; i++) begin
         d = 8'h30 + 8'(i);
         model_frame(d, 1'b1);
         send_frame(d, 1'b1, -1);
      end
      repeat (4) @(posedge clk);
      #1;
      check("b2b_drained", exp_q.size(), 0);

      // Overrun: second byte replaces an unacknowledged first.
      set_auto(1'b0);
      model_frame(8'h31, 1'b1);
      send_frame(8'h31, 1'b1, -1);
      model_frame(8'h32, 1'b1);
      send_frame(8'h32, 1'b1, -1);
      check("overrun_rxbyte", rxbyte, 8'h32);
      check("overrun_rxvalid", rxvalid, 1'b1);

      // Asynchronous reset between clock edges clears outputs at once.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_rxbyte", rxbyte, 8'h00);
      check("async_rst_rxvalid", rxvalid, 1'b0);
      check("async_rst_overrun", overrun, 1'b0);
      check("async_rst_frame_err", frame_err, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_valid = 1'b0;

      // Framing error followed by a break: one pulse, no byte.
      model_frame(8'h55, 1'b0);
      send_frame(8'h55, 1'b0, -1);
      check("ferr_no_valid", rxvalid, 1'b0);
      check("ferr_drained", exp_q.size(), 0);

      // Short low glitch on an idle line is a false start.
      rx = 1'b0;
      repeat (BIT / 4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (2 * BIT) @(posedge clk);
      #1;
      check("glitch_no_valid", rxvalid, 1'b0);

      // Acknowledge in the exact cycle of a new load.
      model_frame(8'hC3, 1'b1);
      send_frame(8'hC3, 1'b1, -1);
      fork
         send_frame(8'h3C, 1'b1, -1);
         begin
            repeat (lat - 1) @(posedge clk);
            #1 manual_ack = 1'b1;
            @(posedge clk);
            #1 manual_ack = 1'b0;
            check("collision_rxvalid", rxvalid, 1'b1);
            check("collision_rxbyte", rxbyte, 8'h3C);
            check("collision_no_overrun", overrun, 1'b0);
         end
      join
      ack_pulse();

      // Reset during data bit 4 loses the frame; the next one is clean.
      send_frame(8'hF0, 1'b1, 4);
      model_valid = 1'b0;
      repeat (BIT) @(posedge clk);
      #1;
      check("midrst_no_valid", rxvalid, 1'b0);
      model_frame(8'h7E, 1'b1);
      send_frame(8'h7E, 1'b1, -1);
      check("midrst_next_rxbyte", rxbyte, 8'h7E);
      ack_pulse();

      // Randomized frames, stop bits, acknowledge modes and idle gaps.
      for (int i = 0; i < 24; i++) begin
         set_auto(1'($urandom_range(0, 1)));
         d  = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
         repeat ($urandom_range(0, BIT)) @(posedge clk);
         #1;
         model_frame(d, ok);
         send_frame(d, ok, -1);
         if (!auto_ack && model_valid && $urandom_range(0, 2) == 0) ack_pulse();
      end

      repeat (BIT) @(posedge clk);
      #1;
      check("final_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
